hazard5_lsu: RTL

//  Load/store unit; M stage, directly downstream of the X-stage ALU. Consumes
//  the ALU sum as the effective address. Issues one single-beat bus access.

---
 rtl/hazard5_lsu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard5_lsu.sv
// rtl/hazard5_lsu.sv - M-stage load/store unit, one single-beat access outstanding
// Optional HAZARD5_LSU_FASTREQ_EN: issue the bus request combinationally from IDLE.
module hazard5_lsu #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic              x_flush,
  input  logic [W_ADDR-1:0] x_addr,
  input  logic [W_DATA-1:0] x_wdata,
  input  logic              x_write,
  input  logic [1:0]        x_size,
  input  logic              x_unsigned,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [W_ADDR-1:0] bus_addr,
  output logic              bus_write,
  output logic [1:0]        bus_size,
  output logic [W_DATA-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic [W_DATA-1:0] bus_rdata,
  input  logic              bus_err,
  output logic              wb_valid,
  output logic [W_DATA-1:0] wb_data,
  output logic              except_misaligned,
  output logic              except_bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state_q, state_d;
  logic [W_ADDR-1:0] addr_q;
  logic [W_DATA-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              write_q, uns_q, flushed_q;
  logic              wb_valid_q, exc_mis_q, exc_bus_q;
  logic [W_DATA-1:0] wb_data_q;

  logic              accept, aligned, completion, killed;
  logic [W_DATA-1:0] x_wdata_rep, rdata_sh, load_ext;

  assign accept     = x_valid & x_ready & ~x_flush;
  assign completion = (state_q == DATA) & bus_rvalid;
  // A flush arriving in the very cycle of the response still kills writeback.
  assign killed     = flushed_q | x_flush;

  always_comb begin
    aligned = 1'b0;
    case (x_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~x_addr[0];
      2'd2:    aligned = (x_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    x_wdata_rep = x_wdata;
    if (x_size == 2'd0)      x_wdata_rep = {4{x_wdata[7:0]}};
    else if (x_size == 2'd1) x_wdata_rep = {2{x_wdata[15:0]}};
  end

  assign rdata_sh = bus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = rdata_sh;
    if (size_q == 2'd0)      load_ext = {{24{~uns_q & rdata_sh[7]}}, rdata_sh[7:0]};
    else if (size_q == 2'd1) load_ext = {{16{~uns_q & rdata_sh[15]}}, rdata_sh[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept & aligned) begin
`ifdef HAZARD5_LSU_FASTREQ_EN
          state_d = bus_gnt ? DATA : ADDR;
`else
          state_d = ADDR;
`endif
        end
      end
      ADDR: begin
        if (bus_gnt)      state_d = DATA;
        else if (x_flush) state_d = IDLE;
      end
      DATA: begin
        if (bus_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_ready   = (state_q == IDLE);
    bus_req   = (state_q == ADDR);
    bus_addr  = addr_q;
    bus_wdata = wdata_q;
    bus_write = write_q;
    bus_size  = size_q;
`ifdef HAZARD5_LSU_FASTREQ_EN
    if (state_q == IDLE) begin
      bus_req   = accept & aligned;
      bus_addr  = x_addr;
      bus_wdata = x_wdata_rep;
      bus_write = x_write;
      bus_size  = x_size;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 2'd0;
      write_q    <= 1'b0;
      uns_q      <= 1'b0;
      flushed_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      exc_mis_q  <= 1'b0;
      exc_bus_q  <= 1'b0;
    end else begin
      wb_valid_q <= completion & ~bus_err & ~killed;
      exc_bus_q  <= completion & bus_err & ~killed;
      exc_mis_q  <= accept & ~aligned;
      if (accept) begin
        addr_q    <= x_addr;
        wdata_q   <= x_wdata_rep;
        size_q    <= x_size;
        write_q   <= x_write;
        uns_q     <= x_unsigned;
        flushed_q <= 1'b0;
      end else if (x_flush & (((state_q == ADDR) & bus_gnt) | (state_q == DATA))) begin
        flushed_q <= 1'b1;
      end
      if (completion) wb_data_q <= write_q ? '0 : load_ext;
    end
  end

  assign wb_valid          = wb_valid_q;
  assign wb_data           = wb_data_q;
  assign except_misaligned = exc_mis_q;
  assign except_bus        = exc_bus_q;

endmodule
